// File: rtl/cnt1_stream_if.sv
`default_nettype none
// cnt1_stream_if: sub-vector word stream in, word + running popcount stream out.
// The slave view belongs to the popcount stage, the master view to whoever drives and drains it.
interface cnt1_stream_if #(
   parameter int BUS_WIDTH = 512,
   parameter int ID_WIDTH  = 8,
   parameter int CNT_WIDTH = 10
);
   logic [BUS_WIDTH-1:0] i_Vector;
   logic                 i_Valid;
   logic                 i_Last;
   logic                 o_Ready;
   logic [BUS_WIDTH-1:0] o_SubVector;
   logic                 o_Valid;
   logic                 i_Ready;
   logic                 o_Last;
   logic [CNT_WIDTH-1:0] o_Cnt;
   logic                 o_CntNew;
   logic [ID_WIDTH-1:0]  o_VecId;
   logic                 o_FrameErr;

   modport slave (
      input  i_Vector, i_Valid, i_Last, i_Ready,
      output o_Ready, o_SubVector, o_Valid, o_Last, o_Cnt, o_CntNew, o_VecId, o_FrameErr
   );

   modport master (
      output i_Vector, i_Valid, i_Last, i_Ready,
      input  o_Ready, o_SubVector, o_Valid, o_Last, o_Cnt, o_CntNew, o_VecId, o_FrameErr
   );
endinterface
`default_nettype wire

// File: rtl/cnt1_stream.sv
`default_nettype none
// cnt1_stream: pipelined per-vector popcount with word-count or i_Last framing, vector IDs
// and a sticky framing/overflow error flag; every stage moves on one global advance enable.
module cnt1_stream #(
   parameter int BUS_WIDTH     = 512,
   parameter int VECTOR_WIDTH  = 920,
   parameter int SUB_VECTOR_NO = 2,
   parameter int ADD_STAGES    = 3,
   parameter int USE_LAST      = 0,
   parameter int ID_WIDTH      = 8,
   parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   cnt1_stream_if.slave bus
);

   // Smallest radix r with r**levels >= bits, so every adder level has the same fan-in.
   function automatic int tree_radix(input int bits, input int levels);
      int r;
      int p;
      r = bits;
      for (int c = bits; c >= 1; c--) begin
         p = 1;
         for (int l = 0; l < levels; l++) begin
            if (p < bits) p = p * c;
         end
         if (p >= bits) r = c;
      end
      return r;
   endfunction

   localparam int PW        = $clog2(BUS_WIDTH + 1);
   localparam int SW        = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
   localparam int RADIX     = tree_radix(BUS_WIDTH, ADD_STAGES);
   localparam int LEAVES    = (BUS_WIDTH + RADIX - 1) / RADIX;
   localparam int LS        = ADD_STAGES - 1;
   localparam logic [3:0] LAST_IDX = 4'(SUB_VECTOR_NO - 1);

   logic                 adv;
   logic                 accept;

   logic [3:0]           word_idx;
   logic                 overrun;
   logic [ID_WIDTH-1:0]  id_cnt;
   logic                 in_first;
   logic                 in_last;
   logic                 in_err;

   logic [PW-1:0]        tree_d [ADD_STAGES][LEAVES];
   logic [PW-1:0]        tree_q [ADD_STAGES][LEAVES];

   logic                 pipe_valid [ADD_STAGES];
   logic                 pipe_first [ADD_STAGES];
   logic                 pipe_last  [ADD_STAGES];
   logic                 pipe_err   [ADD_STAGES];
   logic [ID_WIDTH-1:0]  pipe_id    [ADD_STAGES];
   logic [BUS_WIDTH-1:0] pipe_data  [ADD_STAGES];

   logic [PW-1:0]        word_cnt;
   logic [SW-1:0]        sum;
   logic                 sat;

   logic                 out_valid;
   logic                 out_last;
   logic                 out_err;
   logic [CNT_WIDTH-1:0] acc;
   logic [ID_WIDTH-1:0]  out_id;
   logic [BUS_WIDTH-1:0] out_data;

   assign adv    = !out_valid | bus.i_Ready;
   assign accept = bus.i_Valid & adv;

   // Input-side framing: classify the word being offered this cycle.
   always_comb begin
      in_first = (word_idx == 4'd0);
      if (USE_LAST != 0) begin
         in_last = bus.i_Last;
         in_err  = overrun | (bus.i_Last & (word_idx != LAST_IDX));
      end else begin
         in_last = (word_idx == LAST_IDX);
         in_err  = 1'b0;
      end
   end

   // The counter parks at LAST_IDX when i_Last is overdue; overrun flags the next word.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx <= '0;
         overrun  <= 1'b0;
         id_cnt   <= '0;
      end else if (accept) begin
         if (in_last) begin
            word_idx <= '0;
            overrun  <= 1'b0;
            id_cnt   <= id_cnt + ID_WIDTH'(1);
         end else if (word_idx == LAST_IDX) begin
            overrun  <= 1'b1;
         end else begin
            word_idx <= word_idx + 4'd1;
         end
      end
   end

   // Adder tree: level 0 counts RADIX-bit slices, each later level sums RADIX partials.
   always_comb begin
      logic [PW-1:0] part;
      tree_d = '{default: '0};
      for (int j = 0; j < LEAVES; j++) begin
         part = '0;
         for (int k = 0; k < RADIX && (j * RADIX + k) < BUS_WIDTH; k++) begin
            part = part + PW'(bus.i_Vector[j * RADIX + k]);
         end
         tree_d[0][j] = part;
      end
      for (int s = 1; s < ADD_STAGES; s++) begin
         for (int j = 0; j < LEAVES; j++) begin
            part = '0;
            for (int k = 0; k < RADIX && (j * RADIX + k) < LEAVES; k++) begin
               part = part + tree_q[s-1][j * RADIX + k];
            end
            tree_d[s][j] = part;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < ADD_STAGES; s++) begin
            pipe_valid[s] <= 1'b0;
         end
      end else if (adv) begin
         pipe_valid[0] <= bus.i_Valid;
         for (int s = 1; s < ADD_STAGES; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
         end
      end
   end

   // Payload travels beside the adder levels; its content only matters where valid is set.
   always_ff @(posedge clk) begin
      if (adv) begin
         tree_q        <= tree_d;
         pipe_first[0] <= in_first;
         pipe_last[0]  <= in_last;
         pipe_err[0]   <= in_err;
         pipe_id[0]    <= id_cnt;
         pipe_data[0]  <= bus.i_Vector;
         for (int s = 1; s < ADD_STAGES; s++) begin
            pipe_first[s] <= pipe_first[s-1];
            pipe_last[s]  <= pipe_last[s-1];
            pipe_err[s]   <= pipe_err[s-1];
            pipe_id[s]    <= pipe_id[s-1];
            pipe_data[s]  <= pipe_data[s-1];
         end
      end
   end

   assign word_cnt = tree_q[LS][0];

   always_comb begin
      sum = (pipe_first[LS] ? '0 : SW'(acc)) + SW'(word_cnt);
      sat = |(sum >> CNT_WIDTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
         acc       <= '0;
         out_id    <= '0;
      end else if (adv) begin
         out_valid <= pipe_valid[LS];
         out_last  <= pipe_valid[LS] & pipe_last[LS];
         if (pipe_valid[LS]) begin
            acc     <= sat ? '1 : sum[CNT_WIDTH-1:0];
            out_id  <= pipe_id[LS];
            out_err <= out_err | pipe_err[LS] | sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv && pipe_valid[LS]) begin
         out_data <= pipe_data[LS];
      end
   end

   assign bus.o_Ready     = adv;
   assign bus.o_SubVector = out_data;
   assign bus.o_Valid     = out_valid;
   assign bus.o_Last      = out_last;
   assign bus.o_Cnt       = acc;
   assign bus.o_CntNew    = out_last;
   assign bus.o_VecId     = out_id;
   assign bus.o_FrameErr  = out_err;

endmodule
`default_nettype wire

// File: tb/tb_cnt1_stream.sv
`default_nettype none
// tb_cnt1_stream: directed checks of cnt1_stream in two builds: 512-bit word-count framing (a)
// and 16-bit i_Last framing with a 2-bit vector ID (b).
module tb_cnt1_stream;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cnt1_stream_if #(.BUS_WIDTH(512), .ID_WIDTH(8), .CNT_WIDTH(10)) ifa ();
   cnt1_stream_if #(.BUS_WIDTH(16),  .ID_WIDTH(2), .CNT_WIDTH(6))  ifb ();

   cnt1_stream #(
      .BUS_WIDTH(512), .VECTOR_WIDTH(920), .SUB_VECTOR_NO(2), .ADD_STAGES(3),
      .USE_LAST(0), .ID_WIDTH(8), .CNT_WIDTH(10)
   ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

   cnt1_stream #(
      .BUS_WIDTH(16), .VECTOR_WIDTH(32), .SUB_VECTOR_NO(2), .ADD_STAGES(2),
      .USE_LAST(1), .ID_WIDTH(2), .CNT_WIDTH(6)
   ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   logic [511:0] wq [$];
   bit           lq [$];
   int           cq [$];
   int           id_base;
   int           id_mask;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk(input int n);
      logic [511:0] one;
      one = 512'd1;
      return (one << n) - one;
   endfunction

   task automatic drive(input int which, input logic v, input logic [511:0] d,
                        input logic l, input logic r);
      if (which == 0) begin
         ifa.i_Valid = v; ifa.i_Vector = d; ifa.i_Last = l; ifa.i_Ready = r;
      end else begin
         ifb.i_Valid = v; ifb.i_Vector = d[15:0]; ifb.i_Last = l; ifb.i_Ready = r;
      end
   endtask

   task automatic sample(input int which, output logic ov, output logic ordy,
                         output logic olast, output logic onew, output logic oerr,
                         output logic [511:0] od, output logic [31:0] oc, output logic [31:0] oid);
      if (which == 0) begin
         ov = ifa.o_Valid; ordy = ifa.o_Ready; olast = ifa.o_Last; onew = ifa.o_CntNew;
         oerr = ifa.o_FrameErr; od = ifa.o_SubVector; oc = 32'(ifa.o_Cnt); oid = 32'(ifa.o_VecId);
      end else begin
         ov = ifb.o_Valid; ordy = ifb.o_Ready; olast = ifb.o_Last; onew = ifb.o_CntNew;
         oerr = ifb.o_FrameErr; od = 512'(ifb.o_SubVector); oc = 32'(ifb.o_Cnt);
         oid = 32'(ifb.o_VecId);
      end
   endtask

   task automatic check_idle(input int which, input string pfx);
      logic ov, ordy, olast, onew, oerr;
      logic [511:0] od;
      logic [31:0] oc, oid;
      sample(which, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk({pfx, "_valid"}, ov, 0);
      chk({pfx, "_last"}, olast, 0);
      chk({pfx, "_cntnew"}, onew, 0);
      chk({pfx, "_cnt"}, oc, 0);
      chk({pfx, "_vecid"}, oid, 0);
      chk({pfx, "_frameerr"}, oerr, 0);
      chk({pfx, "_ready"}, ordy, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0, 0, '0, 0, 1);
      drive(1, 0, '0, 0, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check_idle(0, "rst_a");
      check_idle(1, "rst_b");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle(0, "post_rst_a");
      check_idle(1, "post_rst_b");
   endtask

   task automatic clear_plan(input int base, input int mask);
      wq.delete(); lq.delete(); cq.delete();
      id_base = base;
      id_mask = mask;
   endtask

   task automatic add_vec(input int n0, input int n1, input int cnt);
      wq.push_back(mk(n0)); lq.push_back(1'b0);
      wq.push_back(mk(n1)); lq.push_back(1'b1);
      cq.push_back(cnt);
   endtask

   // Streams the planned words, holding i_Ready low for stall_len cycles from stall_start;
   // each visible output word is compared against the head of the plan until it is taken.
   task automatic run_stream(input int which, input int stall_start, input int stall_len,
                             input bit chk_cont);
      int nxt, outs, vec, n;
      bit started;
      logic rdy, vld;
      logic ov, ordy, olast, onew, oerr;
      logic [511:0] od;
      logic [31:0] oc, oid;
      n = wq.size();
      nxt = 0; outs = 0; vec = 0; started = 0;
      for (int cyc = 0; cyc < 200 && outs < n; cyc++) begin
         @(posedge clk); #1;
         rdy = !(cyc >= stall_start && cyc < stall_start + stall_len);
         vld = (nxt < n);
         drive(which, vld, vld ? wq[nxt] : '0, vld ? lq[nxt] : 1'b0, rdy);
         @(negedge clk);
         sample(which, ov, ordy, olast, onew, oerr, od, oc, oid);
         if (chk_cont && started) chk($sformatf("cont_valid_c%0d", cyc), ov, 1);
         if (ov) begin
            started = 1;
            chk($sformatf("w%0d_data", outs), od, wq[outs]);
            chk($sformatf("w%0d_last", outs), olast, lq[outs]);
            chk($sformatf("w%0d_cntnew", outs), onew, lq[outs]);
            chk($sformatf("w%0d_vecid", outs), oid, 32'((id_base + vec) & id_mask));
            if (lq[outs]) chk($sformatf("w%0d_cnt", outs), oc, 32'(cq[vec]));
            if (!rdy) chk($sformatf("stall_ready_c%0d", cyc), ordy, 0);
            if (rdy) begin
               if (lq[outs]) vec++;
               outs++;
            end
         end
         if (vld && ordy) nxt++;
      end
      chk("out_count", outs, n);
      @(posedge clk); #1;
      drive(which, 0, '0, 0, 1);
      @(negedge clk);
      sample(which, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("drained_valid", ov, 0);
   endtask

   task automatic chk_err(input int which, input string tag, input logic exp);
      logic ov, ordy, olast, onew, oerr;
      logic [511:0] od;
      logic [31:0] oc, oid;
      sample(which, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk(tag, oerr, exp);
   endtask

   initial begin
      logic ov, ordy, olast, onew, oerr;
      logic [511:0] od;
      logic [31:0] oc, oid;

      rst = 1'b1;
      drive(0, 0, '0, 0, 1);
      drive(1, 0, '0, 0, 1);
      do_reset();

      // Two-word 920-bit vector: last word appears four cycles after its acceptance.
      @(posedge clk); #1; drive(0, 1, mk(512), 0, 1);
      @(posedge clk); #1; drive(0, 1, mk(408), 0, 1);
      @(posedge clk); #1; drive(0, 0, '0, 0, 1);
      @(negedge clk);
      sample(0, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("lat_early1_valid", ov, 0);
      @(negedge clk);
      sample(0, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("lat_early2_valid", ov, 0);
      @(negedge clk);
      sample(0, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("lat_w0_valid", ov, 1);
      chk("lat_w0_last", olast, 0);
      chk("lat_w0_cntnew", onew, 0);
      chk("lat_w0_data", od, mk(512));
      @(negedge clk);
      sample(0, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("lat_w1_valid", ov, 1);
      chk("lat_w1_last", olast, 1);
      chk("lat_w1_cntnew", onew, 1);
      chk("lat_w1_cnt", oc, 920);
      chk("lat_w1_vecid", oid, 0);
      chk("lat_w1_data", od, mk(408));
      chk("lat_w1_frameerr", oerr, 0);
      @(negedge clk);
      sample(0, ov, ordy, olast, onew, oerr, od, oc, oid);
      chk("lat_after_valid", ov, 0);

      // Back-to-back vectors with totals 1, 0, 920.
      do_reset();
      clear_plan(0, 255);
      add_vec(1, 0, 1);
      add_vec(0, 0, 0);
      add_vec(512, 408, 920);
      run_stream(0, 1000, 0, 1);

      // Five-cycle downstream stall while outputs are flowing.
      do_reset();
      clear_plan(0, 255);
      add_vec(512, 8, 520);
      add_vec(3, 408, 411);
      add_vec(100, 100, 200);
      run_stream(0, 5, 5, 0);
      chk_err(0, "stall_frameerr", 0);

      // Reset after word 0 discards the partial vector.
      do_reset();
      @(posedge clk); #1; drive(0, 1, mk(5), 0, 1);
      do_reset();
      clear_plan(0, 255);
      add_vec(3, 4, 7);
      run_stream(0, 1000, 0, 0);
      chk_err(0, "midrst_frameerr", 0);

      // 512 + 512 exceeds the 10-bit count: saturate and flag.
      clear_plan(1, 255);
      add_vec(512, 512, 1023);
      run_stream(0, 1000, 0, 0);
      chk_err(0, "ovf_frameerr", 1);

      // i_Last framing: five vectors wrap the 2-bit ID.
      do_reset();
      clear_plan(0, 3);
      for (int k = 0; k < 5; k++) add_vec(k + 1, 2, k + 3);
      run_stream(1, 1000, 0, 0);
      chk_err(1, "idwrap_frameerr", 0);

      // i_Last on the first word closes a one-word vector and raises the sticky error.
      clear_plan(1, 3);
      wq.push_back(mk(5)); lq.push_back(1'b1); cq.push_back(5);
      run_stream(1, 1000, 0, 0);
      chk_err(1, "early_last_frameerr", 1);
      clear_plan(2, 3);
      add_vec(16, 16, 32);
      run_stream(1, 1000, 0, 0);
      chk_err(1, "sticky_frameerr", 1);

      // Missing i_Last: the third word is flagged and still accumulated.
      do_reset();
      clear_plan(0, 3);
      wq.push_back(mk(1)); lq.push_back(1'b0);
      wq.push_back(mk(1)); lq.push_back(1'b0);
      wq.push_back(mk(1)); lq.push_back(1'b1);
      cq.push_back(3);
      run_stream(1, 1000, 0, 0);
      chk_err(1, "overrun_frameerr", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
